// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared types and helpers for the pong game core: FSM state
//            encoding, player indices, paddle input decode and paddle clamp.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    // Player index, also used as the server / scorer flag.
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Two-bit signed move request; -2 is folded onto -1 so a paddle never
    // moves more than one unit per frame.
    function automatic int move_of(input logic [1:0] m);
        case (m)
            2'b01:   return 1;
            2'b10:   return -1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    // Saturating clamp of a paddle centre into [lo, hi].
    function automatic int clamp_pos(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pong_axis.sv
// ============================================================================
// Module   : pong_axis
// Purpose  : Combinational single-axis ball step. Adds velocity to position
//            in POS_W+1 bits; at or beyond either limit the position is held
//            and the velocity negated.
// Ports    : pos, vel        current position / velocity (signed)
//            lo, hi          field limits (signed)
//            next_pos        position after this step
//            next_vel        velocity after this step
//            at_edge         step would reach or cross a limit
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module pong_axis #(
    parameter int POS_W = 8,
    parameter int VEL_W = 4
) (
    input  logic signed [POS_W-1:0] pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic signed [POS_W-1:0] lo,
    input  logic signed [POS_W-1:0] hi,
    output logic signed [POS_W-1:0] next_pos,
    output logic signed [VEL_W-1:0] next_vel,
    output logic                    at_edge
);

    logic signed [POS_W:0] pos_ext;
    logic signed [POS_W:0] vel_ext;
    logic signed [POS_W:0] lo_ext;
    logic signed [POS_W:0] hi_ext;
    logic signed [POS_W:0] sum;

    assign pos_ext = {pos[POS_W-1], pos};
    assign vel_ext = {{(POS_W+1-VEL_W){vel[VEL_W-1]}}, vel};
    assign lo_ext  = {lo[POS_W-1], lo};
    assign hi_ext  = {hi[POS_W-1], hi};
    assign sum     = pos_ext + vel_ext;

    assign at_edge  = (sum >= hi_ext) || (sum <= lo_ext);
    assign next_pos = at_edge ? pos : sum[POS_W-1:0];
    assign next_vel = at_edge ? -vel : vel;

endmodule

`default_nettype wire

// File: rtl/pong_engine.sv
// ============================================================================
// Module   : pong_engine
// Purpose  : Two-player pong core with serve/point/game-over FSM, paddle
//            collision, paddle clamping and win score. Game state advances on
//            frame ticks; IDLE/POINT/OVER transitions do not need a tick.
// Config   : PONG_SPEEDUP_EN - each paddle hit raises |vel_x| by one up to
//            MAX_VEL; every serve restores |vel_x| to one.
// Ports    : clk, reset (sync, active-high), tick (frame strobe),
//            start (leave IDLE/OVER), in_p1/in_p2 (2-bit signed move),
//            state, score_p1/score_p2, paddle_p1/paddle_p2, ball_x/ball_y,
//            hit (paddle hit pulse), point ([0] p1 / [1] p2 scored pulse),
//            winner (valid in OVER only)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module pong_engine
    import pong_pkg::*;
#(
    parameter int POS_W       = 8,
    parameter int HALF        = 64,
    parameter int PAD_HALF    = 8,
    parameter int VEL_W       = 4,
    parameter int MAX_VEL     = 4,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    start,
    input  logic [1:0]              in_p1,
    input  logic [1:0]              in_p2,
    output state_t                  state,
    output logic [SCORE_W-1:0]      score_p1,
    output logic [SCORE_W-1:0]      score_p2,
    output logic signed [POS_W-1:0] paddle_p1,
    output logic signed [POS_W-1:0] paddle_p2,
    output logic signed [POS_W-1:0] ball_x,
    output logic signed [POS_W-1:0] ball_y,
    output logic                    hit,
    output logic [1:0]              point,
    output logic [1:0]              winner
);

`ifdef PONG_SPEEDUP_EN
    localparam logic SPEEDUP = 1'b1;
`else
    localparam logic SPEEDUP = 1'b0;
`endif

    localparam int                      CNT_W     = $clog2(SERVE_TICKS) + 1;
    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(SERVE_TICKS - 1);
    localparam logic signed [POS_W-1:0] EDGE_HI   = POS_W'(HALF);
    localparam logic signed [POS_W-1:0] EDGE_LO   = POS_W'(-HALF);
    localparam logic signed [POS_W:0]   PAD_LIM   = (POS_W+1)'(PAD_HALF);
    localparam logic signed [VEL_W-1:0] VEL_ONE   = VEL_W'(1);
    localparam logic signed [VEL_W-1:0] VEL_MAX   = VEL_W'(MAX_VEL);
    localparam logic [SCORE_W-1:0]      SCORE_WIN = SCORE_W'(WIN_SCORE);
    localparam int                      PAD_MIN   = PAD_HALF - HALF;
    localparam int                      PAD_MAX   = HALF - PAD_HALF;

    state_t                  state_next;
    logic [CNT_W-1:0]        serve_cnt;
    logic signed [VEL_W-1:0] vel_x;
    logic signed [VEL_W-1:0] vel_y;
    logic                    server;
    logic                    scorer;

    logic signed [POS_W-1:0] y_pos_n, x_pos_n;
    logic signed [VEL_W-1:0] y_vel_n, x_vel_n;
    logic                    y_edge, x_edge;
    logic signed [POS_W-1:0] pad1_n, pad2_n;
    logic signed [POS_W:0]   dy_p1, dy_p2;
    logic                    near_p1, near_p2, x_hit, x_miss, win_now;
    logic signed [VEL_W-1:0] vx_mag, vx_mag_up, vx_hit;

    pong_axis #(.POS_W(POS_W), .VEL_W(VEL_W)) u_axis_y (
        .pos(ball_y), .vel(vel_y), .lo(EDGE_LO), .hi(EDGE_HI),
        .next_pos(y_pos_n), .next_vel(y_vel_n), .at_edge(y_edge)
    );

    pong_axis #(.POS_W(POS_W), .VEL_W(VEL_W)) u_axis_x (
        .pos(ball_x), .vel(vel_x), .lo(EDGE_LO), .hi(EDGE_HI),
        .next_pos(x_pos_n), .next_vel(x_vel_n), .at_edge(x_edge)
    );

    assign pad1_n = POS_W'(clamp_pos(int'(paddle_p1) + move_of(in_p1), PAD_MIN, PAD_MAX));
    assign pad2_n = POS_W'(clamp_pos(int'(paddle_p2) + move_of(in_p2), PAD_MIN, PAD_MAX));

    // Paddle overlap uses the pre-tick ball y and paddle centre.
    assign dy_p1   = {ball_y[POS_W-1], ball_y} - {paddle_p1[POS_W-1], paddle_p1};
    assign dy_p2   = {ball_y[POS_W-1], ball_y} - {paddle_p2[POS_W-1], paddle_p2};
    assign near_p1 = (dy_p1 <= PAD_LIM) && (dy_p1 >= -PAD_LIM);
    assign near_p2 = (dy_p2 <= PAD_LIM) && (dy_p2 >= -PAD_LIM);

    // An x edge is only a wall for the side the ball travels towards.
    assign x_hit  = x_edge && (vel_x[VEL_W-1] ? near_p1 : near_p2);
    assign x_miss = x_edge && !x_hit;

    // x_vel_n is already reversed; optionally grow its magnitude.
    assign vx_mag    = x_vel_n[VEL_W-1] ? -x_vel_n : x_vel_n;
    assign vx_mag_up = (SPEEDUP && (vx_mag < VEL_MAX)) ? vx_mag + VEL_ONE : vx_mag;
    assign vx_hit    = x_vel_n[VEL_W-1] ? -vx_mag_up : vx_mag_up;

    assign win_now = (scorer == P1) ? (score_p1 == SCORE_WIN) : (score_p2 == SCORE_WIN);
    assign winner  = (state == OVER) ? {score_p2 == SCORE_WIN, score_p1 == SCORE_WIN} : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SERVE;
            SERVE:   if (tick && (serve_cnt == CNT_LAST)) state_next = PLAY;
            PLAY:    if (tick && x_miss) state_next = POINT;
            POINT:   state_next = win_now ? OVER : SERVE;
            OVER:    if (start) state_next = SERVE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            serve_cnt <= '0;
            score_p1  <= '0;
            score_p2  <= '0;
            paddle_p1 <= '0;
            paddle_p2 <= '0;
            ball_x    <= '0;
            ball_y    <= '0;
            vel_x     <= VEL_ONE;
            vel_y     <= VEL_ONE;
            server    <= P1;
            scorer    <= P1;
            hit       <= 1'b0;
            point     <= 2'b00;
        end else begin
            hit   <= 1'b0;
            point <= 2'b00;
            if (state != SERVE) serve_cnt <= '0;
            case (state)
                SERVE: begin
                    ball_x <= '0;
                    ball_y <= '0;
                    vel_y  <= VEL_ONE;
                    vel_x  <= (server == P1) ? VEL_ONE : -VEL_ONE;
                    if (tick) begin
                        serve_cnt <= serve_cnt + CNT_W'(1);
                        paddle_p1 <= pad1_n;
                        paddle_p2 <= pad2_n;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        paddle_p1 <= pad1_n;
                        paddle_p2 <= pad2_n;
                        ball_y    <= y_pos_n;
                        vel_y     <= y_vel_n;
                        if (x_hit) begin
                            vel_x <= vx_hit;
                            hit   <= 1'b1;
                        end else if (x_miss) begin
                            // The player who missed serves next.
                            if (vel_x[VEL_W-1]) begin
                                score_p2 <= score_p2 + SCORE_W'(1);
                                point    <= 2'b10;
                                server   <= P1;
                                scorer   <= P2;
                            end else begin
                                score_p1 <= score_p1 + SCORE_W'(1);
                                point    <= 2'b01;
                                server   <= P2;
                                scorer   <= P1;
                            end
                        end else begin
                            ball_x <= x_pos_n;
                        end
                    end
                end
                OVER: begin
                    if (start) begin
                        score_p1  <= '0;
                        score_p2  <= '0;
                        paddle_p1 <= '0;
                        paddle_p2 <= '0;
                        server    <= P1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pong_engine.sv
// ============================================================================
// Module   : tb_pong_engine
// Purpose  : Directed self-checking bench for pong_engine (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_engine;
    import pong_pkg::*;

    localparam int WIN = 9;

    logic              clk = 1'b0;
    logic              reset, tick, start;
    logic [1:0]        in_p1, in_p2;
    state_t            state;
    logic [3:0]        score_p1, score_p2;
    logic signed [7:0] paddle_p1, paddle_p2, ball_x, ball_y;
    logic              hit;
    logic [1:0]        point, winner;
    logic [1:0]        seen;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pong_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .in_p1(in_p1), .in_p2(in_p2), .state(state),
        .score_p1(score_p1), .score_p2(score_p2),
        .paddle_p1(paddle_p1), .paddle_p2(paddle_p2),
        .ball_x(ball_x), .ball_y(ball_y),
        .hit(hit), .point(point), .winner(winner)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // Ticks until a point pulse shows up; returns 0 if the budget expires.
    task automatic run_until_point(input int max_ticks, output logic [1:0] got_point);
        got_point = 2'b00;
        tick = 1'b1;
        for (int i = 0; i < max_ticks; i++) begin
            step();
            if (point != 2'b00) begin
                got_point = point;
                break;
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; in_p1 = 2'b00; in_p2 = 2'b00;
        repeat (2) step();
        check("rst_state", int'(state), int'(IDLE));
        check("rst_s1", int'(score_p1), 0);
        check("rst_s2", int'(score_p2), 0);
        check("rst_pad1", paddle_p1, 0);
        check("rst_pad2", paddle_p2, 0);
        check("rst_bx", ball_x, 0);
        check("rst_by", ball_y, 0);
        check("rst_hit", int'(hit), 0);
        check("rst_point", int'(point), 0);
        check("rst_winner", int'(winner), 0);
        reset = 1'b0;

        // IDLE ignores ticks, leaves on start alone.
        run_ticks(3);
        check("idle_hold", int'(state), int'(IDLE));
        start = 1'b1; step(); start = 1'b0;
        check("idle_start", int'(state), int'(SERVE));

        // Serve lasts exactly 30 ticks.
        run_ticks(29);
        check("serve_29", int'(state), int'(SERVE));
        run_ticks(1);
        check("serve_30", int'(state), int'(PLAY));
        check("serve_bx", ball_x, 0);
        check("serve_by", ball_y, 0);

        // Diagonal to the right wall; p2 paddle at 0 misses.
        run_ticks(62);
        check("play_bx62", ball_x, 62);
        check("play_by62", ball_y, 62);
        run_ticks(1);
        check("play_by63", ball_y, 63);
        run_ticks(1);
        check("miss_point", int'(point), 1);
        check("miss_s1", int'(score_p1), 1);
        check("miss_state", int'(state), int'(POINT));
        check("miss_by_held", ball_y, 63);
        step();
        check("point_to_serve", int'(state), int'(SERVE));
        check("point_clear", int'(point), 0);

        // p2 serves; paddles saturate; -2 moves like -1.
        in_p1 = 2'b01; in_p2 = 2'b10;
        run_ticks(30);
        check("r2_play", int'(state), int'(PLAY));
        check("r2_pad1_30", paddle_p1, 30);
        check("r2_pad2_m30", paddle_p2, -30);
        in_p2 = 2'b11;
        run_ticks(1);
        check("r2_bx_left", ball_x, -1);
        check("r2_by", ball_y, 1);
        run_ticks(62);
        check("r2_bx", ball_x, -63);
        check("r2_pad1_sat", paddle_p1, 56);
        check("r2_pad2_sat", paddle_p2, -56);
        in_p2 = 2'b00;
        run_ticks(1);
        check("hit_left", int'(hit), 1);
        check("hit_left_bx", ball_x, -63);
        check("hit_left_by", ball_y, 63);
        run_ticks(1);
        check("after_hit_bx", ball_x, -62);
        check("after_hit_by", ball_y, 62);
        check("hit_pulse_end", int'(hit), 0);
        in_p1 = 2'b11;
        run_ticks(125);
        check("r2_bx63", ball_x, 63);
        check("r2_bym63", ball_y, -63);
        run_ticks(1);
        check("hit_right", int'(hit), 1);
        check("hit_right_bx", ball_x, 63);
        run_until_point(300, seen);
        check("p2_point", int'(seen), 2);
        check("p2_score", int'(score_p2), 1);
        check("p2_pad1_sat", paddle_p1, -56);
        step();
        check("p2_serve", int'(state), int'(SERVE));

        // Centre p2 paddle; p1 paddle climbs to the top so p1 wins every rally.
        in_p1 = 2'b01; in_p2 = 2'b01;
        run_ticks(56);
        check("c_pad1", paddle_p1, 0);
        check("c_pad2", paddle_p2, 0);
        in_p2 = 2'b00;
        for (int k = 2; k <= WIN; k++) begin
            run_until_point(400, seen);
            check("win_pt", int'(seen), 1);
            check("win_score", int'(score_p1), k);
            check("win_pt_winner", int'(winner), 0);
            step();
            check("win_next", int'(state), (k == WIN) ? int'(OVER) : int'(SERVE));
        end
        check("over_winner", int'(winner), 1);
        check("over_s2", int'(score_p2), 1);
        run_ticks(5);
        check("over_hold", int'(state), int'(OVER));
        check("over_winner_hold", int'(winner), 1);

        in_p1 = 2'b00;
        start = 1'b1; step(); start = 1'b0;
        check("restart_state", int'(state), int'(SERVE));
        check("restart_s1", int'(score_p1), 0);
        check("restart_s2", int'(score_p2), 0);
        check("restart_pad1", paddle_p1, 0);
        check("restart_pad2", paddle_p2, 0);
        check("restart_winner", int'(winner), 0);
        run_ticks(31);
        check("restart_p1_serves", ball_x, 1);
        start = 1'b1; step(); start = 1'b0;
        check("start_in_play", int'(state), int'(PLAY));

        // reset wins over start and tick.
        reset = 1'b1; start = 1'b1; tick = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; tick = 1'b0;
        check("reset_prio", int'(state), int'(IDLE));
        check("reset_bx", ball_x, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
